// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the program-ROM arbiter.
// Tags are carried at the maximum width and sliced to the configured requester count.
package rom_arb_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 8;
    localparam int MAX_REQ    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        LOCKED
    } arb_state_e;

    typedef logic [MAX_REQ-1:0] req_tag_t;

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N, returned both as a one-hot grant and as an index.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous program ROM between NUM_REQ readers,
// with optional owner lock for bursts and a two-cycle tagged read return.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = ROM_DATA_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ-1:0]        LOCK,
    output logic [NUM_REQ-1:0]        GNT,
    output logic [NUM_REQ-1:0]        RD_VALID,
    output logic [DATA_W-1:0]         RD_DATA,
    output logic [ADDR_W-1:0]         ROM_ADDR,
    input  logic [DATA_W-1:0]         ROM_DATA
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    req_tag_t         tag1_q, tag1_d;
    req_tag_t         tag2_q, tag2_d;
    logic [DATA_W-1:0] rd_hold_q, rd_hold_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   win;
    logic               accept;
    logic               any_req;
    logic [ADDR_W-1:0]  sel_addr;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (REQ),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Grant depends only on REQ, pointer, state and RESET; never on ROM_DATA.
    always_comb begin
        gnt = '0;
        win = pick_idx;
        if (RESET) begin
            gnt = '0;
        end else if (state_q == LOCKED) begin
            win = owner_q;
            if (REQ[owner_q]) begin
                gnt[owner_q] = 1'b1;
            end
        end else begin
            gnt = pick_gnt;
        end
    end

    assign accept   = |gnt;
    assign any_req  = |REQ;
    assign sel_addr = REQ_ADDR[int'(win)*ADDR_W +: ADDR_W];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (state_q == LOCKED) begin
            if (!(accept && LOCK[owner_q])) begin
                state_d = any_req ? ARB : IDLE;
            end
        end else if (accept) begin
            ptr_d = (pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
            if (LOCK[pick_idx]) begin
                state_d = LOCKED;
                owner_d = pick_idx;
            end else begin
                state_d = any_req ? ARB : IDLE;
            end
        end else begin
            state_d = any_req ? ARB : IDLE;
        end
    end

    // Read pipeline: address/tag at the accept edge, tag follows the ROM's own register.
    always_comb begin
        rom_addr_d = accept ? sel_addr : rom_addr_q;
        tag1_d     = req_tag_t'(gnt);
        tag2_d     = tag1_q;
        rd_hold_d  = (|tag2_q) ? ROM_DATA : rd_hold_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            rom_addr_q <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            rom_addr_q <= rom_addr_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    assign GNT      = gnt;
    assign ROM_ADDR = rom_addr_q;
    assign RD_VALID = tag2_q[NUM_REQ-1:0];
    assign RD_DATA  = (|tag2_q) ? ROM_DATA : rd_hold_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a 2-requester instance for the main scenarios
// and a 3-requester instance for pointer wrap. ROM model: ROM[a] = a ^ 8'hA5.
module tb_rom_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;

    logic [1:0]  REQ, LOCK, GNT, RD_VALID;
    logic [15:0] REQ_ADDR;
    logic [7:0]  RD_DATA, ROM_ADDR, ROM_DATA;

    logic [2:0]  REQ_b, LOCK_b, GNT_b, RD_VALID_b;
    logic [23:0] REQ_ADDR_b;
    logic [7:0]  RD_DATA_b, ROM_ADDR_b, ROM_DATA_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [7:0] exp_d [6] = '{8'hA6, 8'hA1, 8'hA0, 8'hA6, 8'hA1, 8'hA0};

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) ROM_DATA   <= ROM_ADDR ^ 8'hA5;
    always_ff @(posedge CLK) ROM_DATA_b <= ROM_ADDR_b ^ 8'hA5;

    rom_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) dut_a (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .LOCK     (LOCK),
        .GNT      (GNT),
        .RD_VALID (RD_VALID),
        .RD_DATA  (RD_DATA),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA)
    );

    rom_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8)) dut_b (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ      (REQ_b),
        .REQ_ADDR (REQ_ADDR_b),
        .LOCK     (LOCK_b),
        .GNT      (GNT_b),
        .RD_VALID (RD_VALID_b),
        .RD_DATA  (RD_DATA_b),
        .ROM_ADDR (ROM_ADDR_b),
        .ROM_DATA (ROM_DATA_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 2-requester instance: drive, check at the falling edge, advance.
    task automatic cyc(input string tag, input logic [1:0] req, input logic [7:0] a0,
                       input logic [7:0] a1, input logic [1:0] lock, input logic [1:0] eg,
                       input logic [1:0] ev, input logic [7:0] ed, input logic [7:0] ea);
        REQ      = req;
        REQ_ADDR = {a1, a0};
        LOCK     = lock;
        @(negedge CLK);
        chk({tag, ".gnt"},  GNT,      eg);
        chk({tag, ".vld"},  RD_VALID, ev);
        chk({tag, ".data"}, RD_DATA,  ed);
        chk({tag, ".addr"}, ROM_ADDR, ea);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        RESET      = 1'b1;
        REQ        = 2'b01;
        REQ_ADDR   = '0;
        LOCK       = '0;
        REQ_b      = '0;
        REQ_ADDR_b = '0;
        LOCK_b     = '0;

        @(negedge CLK);
        chk("rst.gnt",  GNT,      2'b00);
        chk("rst.vld",  RD_VALID, 2'b00);
        chk("rst.data", RD_DATA,  8'h00);
        chk("rst.addr", ROM_ADDR, 8'h00);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // single read from requester 0
        cyc("single0", 2'b01, 8'h10, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 8'h00);
        cyc("single1", 2'b00, 8'h10, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h10);
        cyc("single2", 2'b00, 8'h10, 8'h00, 2'b00, 2'b00, 2'b01, 8'hB5, 8'h10);
        cyc("single3", 2'b00, 8'h10, 8'h00, 2'b00, 2'b00, 2'b00, 8'hB5, 8'h10);

        // requester 1 alone brings the pointer back to 0, then contention
        cyc("pre_rr",  2'b10, 8'h00, 8'h01, 2'b00, 2'b10, 2'b00, 8'hB5, 8'h10);
        cyc("rr0",     2'b11, 8'h00, 8'h01, 2'b00, 2'b01, 2'b00, 8'hB5, 8'h01);
        cyc("rr1",     2'b11, 8'h00, 8'h01, 2'b00, 2'b10, 2'b10, 8'hA4, 8'h00);
        cyc("rr2",     2'b11, 8'h00, 8'h01, 2'b00, 2'b01, 2'b01, 8'hA5, 8'h01);
        cyc("rr3",     2'b11, 8'h00, 8'h01, 2'b00, 2'b10, 2'b10, 8'hA4, 8'h00);
        cyc("rr_tl0",  2'b00, 8'h00, 8'h01, 2'b00, 2'b00, 2'b01, 8'hA5, 8'h01);
        cyc("rr_tl1",  2'b00, 8'h00, 8'h01, 2'b00, 2'b00, 2'b10, 8'hA4, 8'h01);
        cyc("rr_tl2",  2'b00, 8'h00, 8'h01, 2'b00, 2'b00, 2'b00, 8'hA4, 8'h01);

        // lock burst by requester 1; requester 0 stalls until the lock drops
        cyc("lock0",   2'b10, 8'h40, 8'h20, 2'b10, 2'b10, 2'b00, 8'hA4, 8'h01);
        cyc("lock1",   2'b11, 8'h40, 8'h21, 2'b10, 2'b10, 2'b00, 8'hA4, 8'h20);
        cyc("lock2",   2'b11, 8'h40, 8'h22, 2'b00, 2'b10, 2'b10, 8'h85, 8'h21);
        cyc("unlock0", 2'b01, 8'h40, 8'h22, 2'b00, 2'b01, 2'b10, 8'h84, 8'h22);
        cyc("unlock1", 2'b00, 8'h40, 8'h22, 2'b00, 2'b00, 2'b10, 8'h87, 8'h40);
        cyc("unlock2", 2'b00, 8'h40, 8'h22, 2'b00, 2'b00, 2'b01, 8'hE5, 8'h40);

        // idle: everything holds
        for (int i = 0; i < 5; i++) begin
            cyc("idle", 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 8'hE5, 8'h40);
        end

        // reset one cycle after an accept; pointer is 1 going in
        cyc("mid_acc", 2'b01, 8'h30, 8'h00, 2'b00, 2'b01, 2'b00, 8'hE5, 8'h40);
        chk("mid_addr", ROM_ADDR, 8'h30);
        RESET = 1'b1;
        #1;
        chk("async.addr", ROM_ADDR, 8'h00);
        chk("async.vld",  RD_VALID, 2'b00);
        chk("async.data", RD_DATA,  8'h00);
        chk("async.gnt",  GNT,      2'b00);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("inrst.vld", RD_VALID, 2'b00);
            chk("inrst.gnt", GNT,      2'b00);
            @(posedge CLK);
            #1;
        end
        RESET = 1'b0;

        cyc("post0", 2'b11, 8'h50, 8'h60, 2'b00, 2'b01, 2'b00, 8'h00, 8'h00);
        cyc("post1", 2'b10, 8'h50, 8'h60, 2'b00, 2'b10, 2'b00, 8'h00, 8'h50);
        cyc("post2", 2'b00, 8'h50, 8'h60, 2'b00, 2'b00, 2'b01, 8'hF5, 8'h60);
        cyc("post3", 2'b00, 8'h50, 8'h60, 2'b00, 2'b00, 2'b10, 8'hC5, 8'h60);

        // three requesters: pointer wraps from 2 back to 0
        for (int k = 0; k < 8; k++) begin
            REQ_b      = (k < 6) ? 3'b111 : 3'b000;
            REQ_ADDR_b = {8'h05, 8'h04, 8'h03};
            @(negedge CLK);
            if (k < 6) begin
                chk("wrap.gnt", GNT_b, exp_g[k]);
            end else begin
                chk("wrap.gnt_idle", GNT_b, 3'b000);
            end
            if (k >= 2) begin
                chk("wrap.vld",  RD_VALID_b, exp_g[k-2]);
                chk("wrap.data", RD_DATA_b,  exp_d[k-2]);
            end
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("wrap.vld_end",  RD_VALID_b, 3'b000);
        chk("wrap.data_end", RD_DATA_b,  8'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
